// File: rtl/dcache_mem_port.sv
// rtl/dcache_mem_port.sv - D$ memory port: 4-beat line refill and single-word drain over pipelined Wishbone
module dcache_mem_port #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              refill_req_i,
    output logic              refill_ready_o,
    input  logic [ADDR_W-1:0] refill_addr_i,
    output logic [127:0]      refill_line_o,
    output logic              refill_done_o,
    output logic              refill_err_o,
    input  logic              drain_valid_i,
    output logic              drain_ready_o,
    input  logic [ADDR_W-1:0] drain_addr_i,
    input  logic [31:0]       drain_data_i,
    input  logic [3:0]        drain_sel_i,
    output logic              drain_done_o,
    output logic              drain_err_o,
    output logic              mem_cyc_o,
    output logic              mem_stb_o,
    output logic              mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i,
    input  logic              mem_err_i,
    input  logic              mem_stall_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        issue_cnt_q, issue_cnt_d;
    logic [1:0]        ack_cnt_q, ack_cnt_d;
    logic              err_q, err_d;
    logic              issued_q, issued_d;
    logic [ADDR_W-3:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic [127:0]      line_q, line_d;
    logic              refill_done_q, refill_done_d;
    logic              refill_err_q, refill_err_d;
    logic              drain_done_q, drain_done_d;
    logic              drain_err_q, drain_err_d;

    logic              resp;
    logic [31:0]       beat_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{refill_addr_i[3:0], drain_addr_i[1:0]};

    // Only responses inside an open cycle count; errored beats install as zero.
    assign resp      = mem_cyc_o & (mem_ack_i | mem_err_i);
    assign beat_data = mem_err_i ? 32'h0 : mem_rdata_i;

    assign refill_line_o = line_q;
    assign refill_done_o = refill_done_q;
    assign refill_err_o  = refill_err_q;
    assign drain_done_o  = drain_done_q;
    assign drain_err_o   = drain_err_q;

    always_comb begin
        refill_ready_o = 1'b0;
        drain_ready_o  = 1'b0;
        mem_cyc_o      = 1'b0;
        mem_stb_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_sel_o      = 4'h0;
        mem_wdata_o    = 32'h0;
        case (state_q)
            IDLE: begin
                refill_ready_o = !rst_i;
                drain_ready_o  = !rst_i && !refill_req_i;
            end
            READ: begin
                mem_cyc_o  = 1'b1;
                mem_stb_o  = (issue_cnt_q < 3'd4);
                mem_addr_o = {base_q[ADDR_W-3:2], issue_cnt_q[1:0]};
                mem_sel_o  = 4'hF;
            end
            WRITE: begin
                mem_cyc_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_stb_o   = !issued_q;
                mem_addr_o  = base_q;
                mem_sel_o   = sel_q;
                mem_wdata_o = wdata_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        ack_cnt_d     = ack_cnt_q;
        err_d         = err_q;
        issued_d      = issued_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        sel_d         = sel_q;
        line_d        = line_q;
        refill_done_d = 1'b0;
        refill_err_d  = 1'b0;
        drain_done_d  = 1'b0;
        drain_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (refill_req_i) begin
                    base_d      = {refill_addr_i[ADDR_W-1:4], 2'b00};
                    issue_cnt_d = 3'd0;
                    ack_cnt_d   = 2'd0;
                    err_d       = 1'b0;
                    state_d     = READ;
                end else if (drain_valid_i) begin
                    base_d   = drain_addr_i[ADDR_W-1:2];
                    wdata_d  = drain_data_i;
                    sel_d    = drain_sel_i;
                    issued_d = 1'b0;
                    state_d  = WRITE;
                end
            end
            READ: begin
                if (mem_stb_o && !mem_stall_i) begin
                    issue_cnt_d = issue_cnt_q + 3'd1;
                end
                if (resp) begin
                    line_d[{ack_cnt_q, 5'd0} +: 32] = beat_data;
                    ack_cnt_d = ack_cnt_q + 2'd1;
                    err_d     = err_q | mem_err_i;
                    if (ack_cnt_q == 2'd3) begin
                        state_d       = IDLE;
                        refill_done_d = 1'b1;
                        refill_err_d  = err_q | mem_err_i;
                    end
                end
            end
            WRITE: begin
                if (!issued_q && !mem_stall_i) begin
                    issued_d = 1'b1;
                end
                if (resp) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                    drain_err_d  = mem_err_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            issue_cnt_q   <= 3'd0;
            ack_cnt_q     <= 2'd0;
            err_q         <= 1'b0;
            issued_q      <= 1'b0;
            base_q        <= '0;
            wdata_q       <= 32'h0;
            sel_q         <= 4'h0;
            line_q        <= 128'h0;
            refill_done_q <= 1'b0;
            refill_err_q  <= 1'b0;
            drain_done_q  <= 1'b0;
            drain_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            ack_cnt_q     <= ack_cnt_d;
            err_q         <= err_d;
            issued_q      <= issued_d;
            base_q        <= base_d;
            wdata_q       <= wdata_d;
            sel_q         <= sel_d;
            line_q        <= line_d;
            refill_done_q <= refill_done_d;
            refill_err_q  <= refill_err_d;
            drain_done_q  <= drain_done_d;
            drain_err_q   <= drain_err_d;
        end
    end

endmodule

// File: tb/tb_dcache_mem_port.sv
// tb/tb_dcache_mem_port.sv - self-checking bench for dcache_mem_port
module tb_dcache_mem_port;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          refill_req_i, refill_ready_o;
    logic [AW-1:0] refill_addr_i;
    logic [127:0]  refill_line_o;
    logic          refill_done_o, refill_err_o;
    logic          drain_valid_i, drain_ready_o;
    logic [AW-1:0] drain_addr_i;
    logic [31:0]   drain_data_i;
    logic [3:0]    drain_sel_i;
    logic          drain_done_o, drain_err_o;
    logic          mem_cyc_o, mem_stb_o, mem_we_o;
    logic [AW-3:0] mem_addr_o;
    logic [3:0]    mem_sel_o;
    logic [31:0]   mem_wdata_o, mem_rdata_i;
    logic          mem_ack_i, mem_err_i, mem_stall_i;

    always #5 clk_i = ~clk_i;

    dcache_mem_port #(.ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .refill_req_i(refill_req_i), .refill_ready_o(refill_ready_o),
        .refill_addr_i(refill_addr_i), .refill_line_o(refill_line_o),
        .refill_done_o(refill_done_o), .refill_err_o(refill_err_o),
        .drain_valid_i(drain_valid_i), .drain_ready_o(drain_ready_o),
        .drain_addr_i(drain_addr_i), .drain_data_i(drain_data_i),
        .drain_sel_i(drain_sel_i), .drain_done_o(drain_done_o),
        .drain_err_o(drain_err_o),
        .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_stall_i(mem_stall_i)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Memory environment controls
    bit          hand_mode = 1'b1;
    bit          rand_mode = 1'b0;
    int          stall_beat = -1, stall_n = 0, stall_used = 0;
    int          err_idx = -1, resp_sent = 0;
    logic [29:0] pend[$];
    logic [29:0] stb_log[$];

    // Transaction-level reference model: 0 idle, 1 refill, 2 drain
    int           m_kind = 0, m_issued = 0, m_resp = 0;
    bit           m_end = 1'b0, m_err = 1'b0;
    logic [29:0]  m_base;
    logic [31:0]  m_wdata;
    logic [3:0]   m_sel;
    logic [127:0] m_line = '0;
    bit           exp_rdone = 1'b0, exp_rerr, exp_ddone = 1'b0, exp_derr;
    logic [127:0] exp_line;
    bit           seen_rdone, seen_ddone, last_rerr, last_derr;
    logic [127:0] last_line;
    int           n_rdone = 0, n_ddone = 0;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (hand_mode) return 32'hA0 + {30'd0, a[1:0]};
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // One clock: pre-edge checks/model step, edge, post-edge checks, memory drive.
    task automatic cycle();
        int          new_kind;
        bit          e;
        logic [29:0] pa;
        #1;
        chk("refill_ready", refill_ready_o, (m_kind == 0 && !rst_i));
        chk("drain_ready", drain_ready_o, (m_kind == 0 && !rst_i && !refill_req_i));
        if (m_kind != 0 && (mem_ack_i || mem_err_i)) begin
            if (m_kind == 1) begin
                m_line[m_resp*32 +: 32] = mem_err_i ? 32'h0 : mem_rdata_i;
                m_err = m_err | mem_err_i;
                m_resp++;
                if (m_resp == 4) begin
                    exp_rdone = 1'b1; exp_rerr = m_err; exp_line = m_line; m_end = 1'b1;
                end
            end else begin
                exp_ddone = 1'b1; exp_derr = mem_err_i; m_end = 1'b1;
            end
        end
        if (mem_cyc_o && mem_stb_o) stb_log.push_back(mem_addr_o);
        if (mem_cyc_o && mem_stb_o && !mem_stall_i) begin
            if (m_kind == 1) begin
                chk("rd_addr", mem_addr_o, {m_base[29:2], 2'(m_issued)});
                chk("rd_we", mem_we_o, 1'b0);
                chk("rd_sel", mem_sel_o, 4'hF);
                chk("rd_beats", m_issued < 4, 1'b1);
            end else if (m_kind == 2) begin
                chk("wr_addr", mem_addr_o, m_base);
                chk("wr_we", mem_we_o, 1'b1);
                chk("wr_sel", mem_sel_o, m_sel);
                chk("wr_data", mem_wdata_o, m_wdata);
                chk("wr_beats", m_issued, 0);
            end else begin
                chk("stb_when_idle", mem_stb_o, 1'b0);
            end
            m_issued++;
            pend.push_back(mem_addr_o);
        end
        new_kind = 0;
        if (m_kind == 0 && !rst_i) begin
            if (refill_req_i) new_kind = 1;
            else if (drain_valid_i) new_kind = 2;
        end
        @(posedge clk_i);
        #1;
        if (m_end) begin m_kind = 0; m_end = 1'b0; end
        if (new_kind != 0) begin
            m_kind = new_kind; m_issued = 0; m_resp = 0; m_err = 1'b0;
            resp_sent = 0; stall_used = 0;
            if (new_kind == 1) m_base = {refill_addr_i[31:4], 2'b00};
            else begin
                m_base = drain_addr_i[31:2]; m_wdata = drain_data_i; m_sel = drain_sel_i;
            end
        end
        chk("refill_done", refill_done_o, exp_rdone);
        if (exp_rdone) begin
            chk("refill_err", refill_err_o, exp_rerr);
            chk("refill_line", refill_line_o, exp_line);
        end
        chk("drain_done", drain_done_o, exp_ddone);
        if (exp_ddone) chk("drain_err", drain_err_o, exp_derr);
        if (refill_done_o) begin
            n_rdone++; seen_rdone = 1'b1; last_rerr = refill_err_o; last_line = refill_line_o;
        end
        if (drain_done_o) begin
            n_ddone++; seen_ddone = 1'b1; last_derr = drain_err_o;
        end
        exp_rdone = 1'b0;
        exp_ddone = 1'b0;
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        if (pend.size() > 0 && (!rand_mode || $urandom_range(2) != 0)) begin
            pa = pend.pop_front();
            e  = rand_mode ? ($urandom_range(7) == 0) : (resp_sent == err_idx);
            mem_ack_i   = !e;
            mem_err_i   = e;
            mem_rdata_i = e ? $urandom : mem_word(pa);
            resp_sent++;
        end
        if (rand_mode) mem_stall_i = ($urandom_range(3) == 0);
        else if (m_kind != 0 && m_issued == stall_beat && stall_used < stall_n) begin
            mem_stall_i = 1'b1;
            stall_used++;
        end else mem_stall_i = 1'b0;
    endtask

    typedef struct {
        bit           is_refill;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   sel;
        int           stall_beat;
        int           stall_n;
        int           err_idx;
        logic [29:0]  exp_a0;
        int           exp_lat;
        logic [127:0] exp_line;
        bit           exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int i);
        vec_t        v;
        int          lat, nb;
        logic [29:0] exp_log[$];
        v = vecs[i];
        hand_mode = 1'b1; stall_beat = v.stall_beat; stall_n = v.stall_n; err_idx = v.err_idx;
        stb_log.delete(); seen_rdone = 1'b0; seen_ddone = 1'b0;
        if (v.is_refill) begin
            refill_req_i = 1'b1; refill_addr_i = v.addr;
        end else begin
            drain_valid_i = 1'b1; drain_addr_i = v.addr; drain_data_i = v.data; drain_sel_i = v.sel;
        end
        cycle();
        refill_req_i = 1'b0; drain_valid_i = 1'b0;
        lat = 1;
        while (!(seen_rdone || seen_ddone) && lat < 40) begin
            cycle();
            lat++;
        end
        chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
        if (v.is_refill) begin
            chk($sformatf("v%0d_line", i), last_line, v.exp_line);
            chk($sformatf("v%0d_rerr", i), last_rerr, v.exp_err);
        end else begin
            chk($sformatf("v%0d_derr", i), last_derr, v.exp_err);
        end
        nb = v.is_refill ? 4 : 1;
        for (int b = 0; b < nb; b++)
            for (int r = 0; r <= ((b == v.stall_beat) ? v.stall_n : 0); r++)
                exp_log.push_back(v.exp_a0 + 30'(b));
        chk($sformatf("v%0d_stb_count", i), stb_log.size(), exp_log.size());
        for (int k = 0; k < exp_log.size() && k < stb_log.size(); k++)
            chk($sformatf("v%0d_stb_addr%0d", i, k), stb_log[k], exp_log[k]);
        stall_beat = -1; stall_n = 0; err_idx = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdone_at, ddone_at, k;
        vecs[0] = '{1'b1, 32'h1000, 32'h0, 4'h0, -1, 0, -1, 30'h400, 6,
                    128'h000000A3_000000A2_000000A1_000000A0, 1'b0};
        vecs[1] = '{1'b1, 32'h100C, 32'h0, 4'h0, 1, 2, -1, 30'h400, 8,
                    128'h000000A3_000000A2_000000A1_000000A0, 1'b0};
        vecs[2] = '{1'b0, 32'h2004, 32'hDEADBEEF, 4'b0011, -1, 0, -1, 30'h801, 3, 128'h0, 1'b0};
        vecs[3] = '{1'b1, 32'h1000, 32'h0, 4'h0, -1, 0, 2, 30'h400, 6,
                    128'h000000A3_00000000_000000A1_000000A0, 1'b1};
        vecs[4] = '{1'b1, 32'h3FF0, 32'h0, 4'h0, 3, 1, -1, 30'hFFC, 7,
                    128'h000000A3_000000A2_000000A1_000000A0, 1'b0};
        vecs[5] = '{1'b0, 32'h0000, 32'h12345678, 4'hF, -1, 0, 0, 30'h0, 3, 128'h0, 1'b1};

        rst_i = 1'b1;
        refill_req_i = 1'b0; refill_addr_i = '0;
        drain_valid_i = 1'b0; drain_addr_i = '0; drain_data_i = '0; drain_sel_i = '0;
        mem_rdata_i = '0; mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_stall_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_refill_ready", refill_ready_o, 1'b0);
        chk("rst_drain_ready", drain_ready_o, 1'b0);
        chk("rst_cyc", mem_cyc_o, 1'b0);
        chk("rst_stb", mem_stb_o, 1'b0);
        chk("rst_line", refill_line_o, 128'h0);
        chk("rst_dones", {refill_done_o, drain_done_o, refill_err_o, drain_err_o}, 4'h0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 6; i++) run_vec(i);

        // Refill and drain offered together: refill first, drain afterwards.
        hand_mode = 1'b1;
        refill_req_i = 1'b1; refill_addr_i = 32'h1000;
        drain_valid_i = 1'b1; drain_addr_i = 32'h2008; drain_data_i = 32'hCAFEF00D; drain_sel_i = 4'hF;
        #1;
        chk("sim_drain_ready", drain_ready_o, 1'b0);
        chk("sim_refill_ready", refill_ready_o, 1'b1);
        n_rdone = 0; n_ddone = 0; rdone_at = -1; ddone_at = -1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (c == 0) refill_req_i = 1'b0;
            if (m_kind == 2) drain_valid_i = 1'b0;
            if (refill_done_o && rdone_at < 0) rdone_at = c;
            if (drain_done_o && ddone_at < 0) ddone_at = c;
        end
        drain_valid_i = 1'b0;
        chk("sim_refill_pulses", n_rdone, 1);
        chk("sim_drain_pulses", n_ddone, 1);
        chk("sim_refill_done_at", rdone_at, 5);
        chk("sim_drain_done_at", ddone_at, 8);

        // Reset in the middle of a refill.
        refill_req_i = 1'b1; refill_addr_i = 32'h1000;
        cycle();
        refill_req_i = 1'b0;
        k = 0;
        while (m_resp < 1 && k < 20) begin cycle(); k++; end
        chk("abort_reached_beat", m_resp >= 1, 1'b1);
        chk("abort_cyc_before", mem_cyc_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("abort_cyc", mem_cyc_o, 1'b0);
        chk("abort_stb", mem_stb_o, 1'b0);
        m_kind = 0; m_end = 1'b0; pend.delete(); exp_rdone = 1'b0; exp_ddone = 1'b0;
        mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_stall_i = 1'b0;
        n_rdone = 0; n_ddone = 0;
        repeat (2) cycle();
        rst_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        repeat (3) cycle();
        chk("abort_no_refill_done", n_rdone, 0);
        chk("abort_no_drain_done", n_ddone, 0);
        chk("abort_line_untouched", refill_line_o, 128'h0);
        run_vec(0);

        // Randomized traffic against the model.
        hand_mode = 1'b0; rand_mode = 1'b1;
        for (int c = 0; c < 600; c++) begin
            refill_req_i  = ($urandom_range(5) == 0);
            refill_addr_i = $urandom;
            drain_valid_i = ($urandom_range(2) == 0);
            drain_addr_i  = $urandom;
            drain_data_i  = $urandom;
            drain_sel_i   = 4'($urandom);
            cycle();
        end
        refill_req_i = 1'b0; drain_valid_i = 1'b0;
        k = 0;
        while ((m_kind != 0 || pend.size() != 0) && k < 200) begin cycle(); k++; end
        chk("rand_drained", k < 200, 1'b1);
        rand_mode = 1'b0;
        repeat (2) cycle();
        chk("final_ready", refill_ready_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
